// File: rtl/btb_update_queue_pkg.sv
// Shared types and constants for the BTB update queue: field widths, PC slicing,
// controller states and the queued BTB write entry.
package btb_update_queue_pkg;

   localparam int BTB_IDX_W  = 13;
   localparam int BTB_TAG_W  = 8;
   localparam int BTB_TGT_W  = 32;
   localparam int PC_W       = 32;
   localparam int PC_IDX_LSB = 2;
   localparam int PC_TAG_LSB = PC_IDX_LSB + BTB_IDX_W;

   localparam logic [BTB_IDX_W-1:0] SWEEP_LAST = 13'h1FFF;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } state_e;

   typedef struct packed {
      logic [BTB_IDX_W-1:0] waddr;
      logic                 v;
      logic [BTB_TAG_W-1:0] bia;
      logic [BTB_TGT_W-1:0] bta;
   } btb_entry_t;

   // Not-taken updates invalidate the entry, so their target is forced to zero.
   function automatic btb_entry_t make_entry(input logic [PC_W-1:0]      pc,
                                             input logic                 taken,
                                             input logic [BTB_TGT_W-1:0] target);
      btb_entry_t e;
      e.waddr = pc[PC_IDX_LSB +: BTB_IDX_W];
      e.v     = taken;
      e.bia   = pc[PC_TAG_LSB +: BTB_TAG_W];
      e.bta   = taken ? target : {BTB_TGT_W{1'b0}};
      return e;
   endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Synchronous FIFO of BTB write entries with bulk clear and in-place
// overwrite of the newest entry.
module btb_upd_fifo
   import btb_update_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       clr_i,
   input  logic       push_i,
   input  logic       ovr_i,
   input  logic       pop_i,
   input  btb_entry_t wdata_i,
   output btb_entry_t head_o,
   output btb_entry_t tail_o,
   output logic       empty_o,
   output logic       full_o,
   output logic       single_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   btb_entry_t    mem_q [DEPTH];
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW:0]   cnt_q, cnt_d;

   always_comb begin
      rptr_d = rptr_q;
      wptr_d = wptr_q;
      cnt_d  = cnt_q;
      if (clr_i) begin
         rptr_d = {AW{1'b0}};
         wptr_d = {AW{1'b0}};
         cnt_d  = {(AW+1){1'b0}};
      end else begin
         if (push_i) begin
            wptr_d = wptr_q + PTR_ONE;
         end else begin
            wptr_d = wptr_q;
         end
         if (pop_i) begin
            rptr_d = rptr_q + PTR_ONE;
         end else begin
            rptr_d = rptr_q;
         end
         case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rptr_q <= {AW{1'b0}};
         wptr_q <= {AW{1'b0}};
         cnt_q  <= {(AW+1){1'b0}};
      end else begin
         rptr_q <= rptr_d;
         wptr_q <= wptr_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i && !clr_i) begin
         mem_q[wptr_q] <= wdata_i;
      end else if (ovr_i && !clr_i) begin
         mem_q[wptr_q - PTR_ONE] <= wdata_i;
      end
   end

   assign head_o   = mem_q[rptr_q];
   assign tail_o   = mem_q[wptr_q - PTR_ONE];
   assign empty_o  = (cnt_q == {(AW+1){1'b0}});
   assign full_o   = (cnt_q == CNT_FULL);
   assign single_o = (cnt_q == CNT_ONE);

endmodule

// File: rtl/btb_update_queue.sv
// Queues resolved-branch updates into BTB writes and runs a full-table invalidate
// sweep on request. Optional same-index coalescing: BTB_UPD_COALESCE_EN.
module btb_update_queue
   import btb_update_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 upd_valid,
   output logic                 upd_ready,
   input  logic [PC_W-1:0]      upd_pc,
   input  logic                 upd_taken,
   input  logic [BTB_TGT_W-1:0] upd_target,
   input  logic                 flush_req,
   output logic                 flush_busy,
   output logic                 btb_wen,
   output logic [BTB_IDX_W-1:0] btb_waddr,
   output logic                 btb_V,
   output logic [BTB_TAG_W-1:0] btb_BIA,
   output logic [BTB_TGT_W-1:0] btb_BTA
);

   state_e               state_q, state_d;
   logic [BTB_IDX_W-1:0] cnt_q, cnt_d;
   btb_entry_t           out_q, out_d;
   logic                 wen_q, wen_d;
   logic                 busy_q, busy_d;

   btb_entry_t upd_entry_s, head_s, tail_s;
   logic       empty_s, full_s, single_s;
   logic       idle_s, pop_s, hit_s, accept_s, push_s, ovr_s, clr_s;

   assign upd_entry_s = make_entry(upd_pc, upd_taken, upd_target);
   assign idle_s      = (state_q == ST_IDLE);
   assign pop_s       = !rst && idle_s && !flush_req && !empty_s;
   assign clr_s       = idle_s && flush_req;

`ifdef BTB_UPD_COALESCE_EN
   // Only the newest entry may absorb an update, and never while it is leaving.
   assign hit_s = !empty_s && (tail_s.waddr == upd_entry_s.waddr) && !(pop_s && single_s);
`else
   logic unused_s;
   assign unused_s = ^{tail_s, single_s};
   assign hit_s    = 1'b0;
`endif

   assign upd_ready = !rst && idle_s && !flush_req && (!full_s || hit_s);
   assign accept_s  = upd_valid && upd_ready;
   assign push_s    = accept_s && !hit_s;
   assign ovr_s     = accept_s && hit_s;

   btb_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i    (clk),
      .rst_i    (rst),
      .clr_i    (clr_s),
      .push_i   (push_s),
      .ovr_i    (ovr_s),
      .pop_i    (pop_s),
      .wdata_i  (upd_entry_s),
      .head_o   (head_s),
      .tail_o   (tail_s),
      .empty_o  (empty_s),
      .full_o   (full_s),
      .single_o (single_s)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= {BTB_IDX_W{1'b0}};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (flush_req) begin
               state_d = ST_FLUSH;
               cnt_d   = {BTB_IDX_W{1'b0}};
            end else begin
               state_d = ST_IDLE;
               cnt_d   = cnt_q;
            end
         end
         ST_FLUSH: begin
            cnt_d = cnt_q + 13'd1;
            if (cnt_q == SWEEP_LAST) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_FLUSH;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = {BTB_IDX_W{1'b0}};
         end
      endcase
   end

   // Busy covers the flush state plus the cycle presenting the last sweep write.
   always_comb begin
      out_d  = out_q;
      wen_d  = 1'b0;
      busy_d = (state_d == ST_FLUSH) || (state_q == ST_FLUSH);
      case (state_q)
         ST_IDLE: begin
            if (pop_s) begin
               wen_d = 1'b1;
               out_d = head_s;
            end else begin
               wen_d = 1'b0;
               out_d = out_q;
            end
         end
         ST_FLUSH: begin
            wen_d       = 1'b1;
            out_d.waddr = cnt_q;
            out_d.v     = 1'b0;
            out_d.bia   = {BTB_TAG_W{1'b0}};
            out_d.bta   = {BTB_TGT_W{1'b0}};
         end
         default: begin
            wen_d = 1'b0;
            out_d = out_q;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q  <= {$bits(btb_entry_t){1'b0}};
         wen_q  <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         out_q  <= out_d;
         wen_q  <= wen_d;
         busy_q <= busy_d;
      end
   end

   assign btb_wen    = wen_q;
   assign btb_waddr  = out_q.waddr;
   assign btb_V      = out_q.v;
   assign btb_BIA    = out_q.bia;
   assign btb_BTA    = out_q.bta;
   assign flush_busy = busy_q;

endmodule

// File: tb/tb_btb_update_queue.sv
// Randomized scoreboard bench for btb_update_queue: a queue-based reference model
// predicts each cycle's BTB write; a monitor compares on every cycle.
module tb_btb_update_queue;

   localparam int DEPTH = 4;

   typedef struct {
      int unsigned idx;
      bit          v;
      int unsigned tag;
      int unsigned tgt;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst, upd_valid, upd_taken, flush_req;
   logic [31:0] upd_pc, upd_target;
   logic        upd_ready, flush_busy, btb_wen, btb_V;
   logic [12:0] btb_waddr;
   logic [7:0]  btb_BIA;
   logic [31:0] btb_BTA;

   always #5 clk = ~clk;

   btb_update_queue #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .upd_valid  (upd_valid),
      .upd_ready  (upd_ready),
      .upd_pc     (upd_pc),
      .upd_taken  (upd_taken),
      .upd_target (upd_target),
      .flush_req  (flush_req),
      .flush_busy (flush_busy),
      .btb_wen    (btb_wen),
      .btb_waddr  (btb_waddr),
      .btb_V      (btb_V),
      .btb_BIA    (btb_BIA),
      .btb_BTA    (btb_BTA)
   );

   int  n_cmp = 0;
   int  n_mis = 0;
   wr_t exp_q[$];
   wr_t m_q[$];
   bit          m_flush   = 1'b0;
   int unsigned m_cnt     = 0;
   bit          exp_busy  = 1'b0;
   bit          exp_zero  = 1'b0;
   bit          started   = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic wr_t mk(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
      wr_t e;
      e.idx = (pc / 4) % 8192;
      e.tag = (pc / 32768) % 256;
      e.v   = tk;
      e.tgt = tk ? tgt : 0;
      return e;
   endfunction

   // One cycle of stimulus plus the reference model's view of that cycle.
   task automatic step(input bit v, input logic [31:0] pc, input bit tk,
                       input logic [31:0] tgt, input bit fl, input bit r);
      wr_t e;
      bit  hit, pop, rdy;
      int  sz;
      @(negedge clk);
      rst = r; upd_valid = v; upd_pc = pc; upd_taken = tk; upd_target = tgt; flush_req = fl;
      #1;
      started = 1'b1;
      e   = mk(pc, tk, tgt);
      sz  = m_q.size();
      pop = !r && !m_flush && !fl && (sz > 0);
      hit = 1'b0;
`ifdef BTB_UPD_COALESCE_EN
      if (sz > 0) hit = (m_q[sz-1].idx == e.idx) && !(pop && sz == 1);
`endif
      rdy = !r && !m_flush && !fl && ((sz < DEPTH) || hit);
      check("upd_ready", upd_ready, rdy);
      exp_zero = r;
      if (r) begin
         m_q.delete(); m_flush = 1'b0; m_cnt = 0; exp_busy = 1'b0;
      end else if (m_flush) begin
         exp_q.push_back('{m_cnt, 1'b0, 0, 0});
         exp_busy = 1'b1;
         if (m_cnt == 8191) m_flush = 1'b0;
         m_cnt = (m_cnt + 1) % 8192;
      end else if (fl) begin
         m_q.delete(); m_flush = 1'b1; m_cnt = 0; exp_busy = 1'b1;
      end else begin
         exp_busy = 1'b0;
         if (v && rdy && hit) m_q[sz-1] = e;
         if (pop) exp_q.push_back(m_q.pop_front());
         if (v && rdy && !hit) m_q.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   // Monitor: every cycle the outputs must match exactly what the model scheduled.
   initial begin : monitor
      wr_t e;
      forever begin
         @(posedge clk);
         #1;
         if (started) begin
            check("flush_busy", flush_busy, exp_busy);
            if (exp_zero) begin
               check("rst_wen", btb_wen, 1'b0);
               check("rst_waddr", btb_waddr, 13'h0);
               check("rst_V", btb_V, 1'b0);
               check("rst_BIA", btb_BIA, 8'h0);
               check("rst_BTA", btb_BTA, 32'h0);
            end else if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("btb_wen", btb_wen, 1'b1);
               check("btb_waddr", btb_waddr, e.idx);
               check("btb_V", btb_V, e.v);
               check("btb_BIA", btb_BIA, e.tag);
               check("btb_BTA", btb_BTA, e.tgt);
            end else begin
               check("btb_wen_idle", btb_wen, 1'b0);
            end
         end
      end
   end

   initial begin : stim
      bit          found;
      logic [31:0] pc;
      rst = 1'b1; upd_valid = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0;
      upd_target = 32'h0; flush_req = 1'b0;

      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);

      // Directed mapping cases: taken install, not-taken invalidate, nonzero tag.
      step(1'b1, 32'h0000_1008, 1'b1, 32'h0000_2000, 1'b0, 1'b0);
      idle(2);
      step(1'b1, 32'h0080_0004, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
      step(1'b1, 32'h0000_8004, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
      idle(2);

      // Four back-to-back accepts, flush arriving with the fifth, full sweep.
      for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b1, $urandom, 1'b0, 1'b0);
      step(1'b1, 32'h0000_0040, 1'b1, 32'h0000_0080, 1'b1, 1'b0);
      for (int i = 0; i < 8200; i++)
         step(1'(($urandom_range(0, 1))), $urandom, 1'b1, $urandom,
              (i < 8000) ? 1'(($urandom_range(0, 1))) : 1'b0, 1'b0);
      idle(3);

      // Same-index updates in consecutive cycles.
      step(1'b1, 32'h0000_4010, 1'b1, 32'hAAAA_0000, 1'b0, 1'b0);
      step(1'b1, 32'h0000_4010, 1'b1, 32'hBBBB_0000, 1'b0, 1'b0);
      idle(3);

      // Random traffic over a small index set, with occasional resets.
      for (int i = 0; i < 1500; i++) begin
         pc = $urandom & 32'h0180_801C;
         step(1'($urandom_range(0, 9) < 7), pc, 1'(($urandom_range(0, 1))), $urandom,
              1'b0, 1'($urandom_range(0, 199) == 0));
      end
      idle(3);

      // Reset in the middle of a sweep, at index 100.
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         if (btb_wen === 1'b1 && btb_waddr === 13'd100) found = 1'b1;
         else idle(1);
      end
      check("sweep_reached_100", found, 1'b1);
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      idle(20);

      @(posedge clk);
      #2;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
